// File: rtl/lap_stopwatch_if.sv
// Button inputs and display/status outputs of the lap stopwatch core.
// The board top (or bench) drives the buttons through the master side.
// The core uses the slave side.
interface lap_stopwatch_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    btn_run;
  logic                    btn_lap;
  logic                    btn_clr;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    running;
  logic                    lap_active;
  logic                    overflow;
  logic                    tick;

  modport master (
    output btn_run, btn_lap, btn_clr,
    input  disp_bcd, running, lap_active, overflow, tick
  );

  modport slave (
    input  btn_run, btn_lap, btn_clr,
    output disp_bcd, running, lap_active, overflow, tick
  );
endinterface

// File: rtl/lap_stopwatch.sv
// Single-clock lap stopwatch.
// Three debounced buttons act on release. Digits alternate between mod-10
// and mod-6 (units/tens pairs). A lap freezes the display on a snapshot.
// All outputs are registered, one sclk behind the count/state they show.
module lap_stopwatch #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DB_HZ      = 400,
  parameter int NUM_DIGITS = 4,
  parameter int WRAP       = 1
) (
  input  logic           sclk,
  input  logic           reset_n,
  lap_stopwatch_if.slave bus
);
  localparam int W        = 4 * NUM_DIGITS;
  localparam int DB_DIV   = CLK_HZ / DB_HZ;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DBW      = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_DIV - 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam int B_LAP = 0;
  localparam int B_RUN = 1;
  localparam int B_CLR = 2;

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP_RUN, LAP_PAUSE} state_t;

  function automatic logic [3:0] digit_max(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  function automatic logic is_full(input logic [W-1:0] v);
    logic f;
    f = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != digit_max(i)) f = 1'b0;
    return f;
  endfunction

  // Ripple-carry increment across all digits in one cycle.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [DBW-1:0] db_cnt_q;
  logic           db_en;
  logic [2:0]     raw_btn, sync1_q, sync2_q, smp_q, act;
  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d, snap_q, snap_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic           ovf_q, ovf_d, inc_q, inc_d, count_en;
  logic           run_st, lap_st;
  logic [W-1:0]   disp_q;
  logic           running_q, lap_q, ovf_out_q, tick_q;

  assign raw_btn = {bus.btn_clr, bus.btn_run, bus.btn_lap};
  assign db_en   = (db_cnt_q == DB_LAST);
  // A release is a sampled 1 followed by a sampled 0; at most one per press.
  assign act     = {3{db_en}} & smp_q & ~sync2_q;
  assign run_st  = (state_q == RUN) || (state_q == LAP_RUN);
  assign lap_st  = (state_q == LAP_RUN) || (state_q == LAP_PAUSE);

  // Free-running sample enable, synchronisers and per-button sample register.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      smp_q    <= '0;
    end else begin
      db_cnt_q <= db_en ? '0 : db_cnt_q + 1'b1;
      sync1_q  <= raw_btn;
      sync2_q  <= sync1_q;
      if (db_en) smp_q <= sync2_q;
    end
  end

  // Next state, prescaler, count, snapshot and overflow; clr beats run beats lap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    pre_d    = pre_q;
    ovf_d    = ovf_q;
    inc_d    = 1'b0;
    count_en = 1'b0;
    if (run_st) begin
      if (pre_q == PRE_LAST) begin
        pre_d    = '0;
        count_en = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (count_en) begin
      if (is_full(cnt_q)) begin
        ovf_d = 1'b1;
        if (WRAP != 0) begin
          cnt_d = '0;
          inc_d = 1'b1;
        end
      end else begin
        cnt_d = bcd_inc(cnt_q);
        inc_d = 1'b1;
      end
    end
    if (act[B_CLR]) begin
      state_d = IDLE;
      cnt_d   = '0;
      snap_d  = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
      inc_d   = 1'b0;
    end else if (act[B_RUN]) begin
      case (state_q)
        IDLE, PAUSE: state_d = RUN;
        RUN:         state_d = PAUSE;
        LAP_RUN:     state_d = LAP_PAUSE;
        LAP_PAUSE:   state_d = LAP_RUN;
        default:     state_d = IDLE;
      endcase
    end else if (act[B_LAP]) begin
      case (state_q)
        RUN: begin
          state_d = LAP_RUN;
          snap_d  = cnt_d;
        end
        LAP_RUN:   state_d = RUN;
        LAP_PAUSE: state_d = PAUSE;
        default:   state_d = state_q;
      endcase
    end
  end

  // State and counting registers.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      pre_q   <= '0;
      ovf_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
      inc_q   <= inc_d;
    end
  end

  // Output registers; tick is delayed with the display so both change together.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q    <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      disp_q    <= lap_st ? snap_q : cnt_q;
      running_q <= run_st;
      lap_q     <= lap_st;
      ovf_out_q <= ovf_q;
      tick_q    <= inc_q;
    end
  end

  assign bus.disp_bcd   = disp_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_q;
  assign bus.overflow   = ovf_out_q;
  assign bus.tick       = tick_q;
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised single-clock stopwatch core; successor to the four-digit mm:ss stopwatch.
- Adds a lap/split display freeze, a separate clear button, a wrap-or-saturate overflow policy and a configurable digit count.
- Uses one-cycle clock enables instead of derived clocks.
- Feeds the existing LED display driver with a packed BCD bus and sits directly under the board top level.

Parameters:
- CLK_HZ, 100_000_000, sclk frequency.
- TICK_HZ, 1, count rate in least-significant-digit increments per second.
- DB_HZ, 400, button sample rate.
- NUM_DIGITS, 4, BCD digit count; even, legal range 2..8.
- WRAP, 1. 1: wrap to zero at full scale. 0: saturate at full scale.

Ports:
- sclk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- btn_run, input, 1, raw run/pause button, active-high.
- btn_lap, input, 1, raw lap button, active-high.
- btn_clr, input, 1, raw clear button, active-high.
- disp_bcd, output, 4*NUM_DIGITS, digits for display; digit 0 at [3:0].
- running, output, 1, high in RUN or LAP_RUN.
- lap_active, output, 1, high in LAP_RUN or LAP_PAUSE.
- overflow, output, 1, sticky full-scale flag.
- tick, output, 1, one-cycle pulse on each count increment.

Behaviour:
- Reset (reset_n low, async): outputs all 0; state IDLE; count, snapshot, prescaler and debounce registers all 0.
- Enables:
  - db_en: one-cycle pulse every CLK_HZ/DB_HZ cycles, free-running.
  - count_en: one-cycle pulse when the prescaler reaches CLK_HZ/TICK_HZ-1.
  - Prescaler advances only in RUN or LAP_RUN and holds its value in pause states (sub-tick resume accuracy).
  - Prescaler clears on clear and on reset.
- Debounce:
  - Per button, 2-flop synchroniser, then a sample register loaded on db_en.
  - Action pulse (1 sclk) fires on release: previous sample 1, new sample 0.
  - A press held any length yields exactly one action.
- Simultaneous actions in one cycle: clr > run > lap; lower-priority actions are dropped.
- FSM, states IDLE, RUN, PAUSE, LAP_RUN, LAP_PAUSE:
  - IDLE: run->RUN; lap ignored.
  - RUN: run->PAUSE; lap->LAP_RUN and snapshot<=count (value after any same-cycle increment).
  - PAUSE: run->RUN; lap ignored.
  - LAP_RUN: run->LAP_PAUSE; lap->RUN (display goes live).
  - LAP_PAUSE: run->LAP_RUN; lap->PAUSE.
  - Any state: clr->IDLE; count, snapshot, prescaler and overflow cleared.
- Counting:
  - Digit i modulus: 10 for even i, 6 for odd i (units/tens pairs, e.g. mm:ss).
  - Carry ripples through all digits in the count_en cycle.
  - Full scale: every digit at its max (5959 for 4 digits).
  - Full scale with WRAP=1: next count_en gives all zero and sets overflow; counting continues.
  - Full scale with WRAP=0: count holds, overflow set, further count_en ignored, tick suppressed, state unchanged.
  - overflow cleared only by clr or reset.
- Output timing:
  - disp_bcd is registered: shows live count when not lap_active, else snapshot.
  - Latency one sclk after a count or state change.
  - running, lap_active and tick are registered, aligned with disp_bcd.
- Reset mid-count or mid-debounce: immediate zero; no action pulse generated on release.

Test Plan:
Sim parameters: CLK_HZ=1000, TICK_HZ=100 (10 cycles/tick), DB_HZ=500 (2 cycles/sample).
- Reset, then press and release run.
  - Required: running=1 within 6 cycles of release.
  - Required: after 100 further cycles, disp_bcd=0x0010 (10 ticks, carry into digit 1).
- Run to 9 ticks, pause 50 cycles, resume.
  - Required: count holds 0x0009 during pause.
  - Required: next tick lands 10 cycles after pause entry, counting paused time as zero; disp 0x0010.
- Run to 0x0012, press lap.
  - Required: disp frozen at 0x0012 while running=1 and internal count advances.
  - Then lap again after 5 ticks: disp shows 0x0017.
- Preload by running to 0x5959, WRAP=1.
  - Required: next tick gives disp 0x0000 and overflow=1.
  - Repeat with WRAP=0: holds 0x5959, overflow=1, tick stays 0.
- Release run, lap and clr in the same cycle while in LAP_RUN.
  - Required: state IDLE, disp 0x0000, overflow 0, lap_active 0.
- Hold btn_run high 200 cycles with 1-cycle glitches, then release.
  - Required: exactly one action (RUN).
  - Assert reset_n low mid-run: all outputs 0 asynchronously.
